compare_reduce_unit: RTL and testbench

Streaming reduction engine that consumes a vector of operands one element per cycle and keeps a running winner using unsigned compare predicates. Supported predicates are max, min, argmax and argmin. It sits downstream of the SIMD comparison path: the comparison unit turns a data pair into a 0/1 predicate, and this block turns a stream of data plus predicates back into a selected data value and index. A valid/ready handshake carries the result to the writeback stage.

---
 rtl/compare_reduce_unit.sv | 128 ++++++++++++
 tb/tb_compare_reduce_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_reduce_unit.sv
// compare_reduce_unit: streaming max/min/argmax/argmin reduction over a
// vector of unsigned operands, one element per cycle, with a valid/ready
// handshake on the result side.
module compare_reduce_unit #(
  parameter int FUNCTION_BITS = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int INDEX_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FUNCTION_BITS-1:0] fn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIT_WIDTH-1:0]     in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BIT_WIDTH-1:0]     out_data,
  output logic [INDEX_BITS-1:0]    out_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [FUNCTION_BITS-1:0] FN_MIN    = FUNCTION_BITS'(1);
  localparam logic [FUNCTION_BITS-1:0] FN_ARGMIN = FUNCTION_BITS'(3);

  state_t                   state_q, state_d;
  logic [BIT_WIDTH-1:0]     best_q, best_d;
  logic [INDEX_BITS-1:0]    best_idx_q, best_idx_d;
  logic [INDEX_BITS-1:0]    cnt_q, cnt_d;
  logic [FUNCTION_BITS-1:0] fn_q, fn_d;
  logic [BIT_WIDTH-1:0]     out_data_q, out_data_d;
  logic [INDEX_BITS-1:0]    out_index_q, out_index_d;

  logic accept;
  logic use_min;
  logic replace;
  logic supported;

  // Handshake decode: ready depends on state only, never on out_ready.
  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
  end

  // Next-state, accumulator and result computation.
  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    cnt_d       = cnt_q;
    fn_d        = fn_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    use_min     = (fn_q == FN_MIN) || (fn_q == FN_ARGMIN);
    replace     = use_min ? (in_data < best_q) : (in_data > best_q);
    supported   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          best_d     = in_data;
          best_idx_d = '0;
          cnt_d      = INDEX_BITS'(1);
          fn_d       = fn;
          state_d    = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (replace) begin
            best_d     = in_data;
            best_idx_d = cnt_q;
          end
          cnt_d = cnt_q + INDEX_BITS'(1);
          if (in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The result is captured on the in_last beat so it reflects that element.
    if (accept && in_last) begin
      supported   = (fn_d <= FN_ARGMIN);
      out_data_d  = supported ? best_d : '0;
      out_index_d = supported ? best_idx_d : '0;
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      best_q      <= '0;
      best_idx_q  <= '0;
      cnt_q       <= '0;
      fn_q        <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      cnt_q       <= cnt_d;
      fn_q        <= fn_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_compare_reduce_unit.sv
// Testbench for compare_reduce_unit: scenario tasks drive vectors, a
// reference model pushes expected results into a queue, and each task pops
// and compares when the DUT presents its result.
module tb_compare_reduce_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  fn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_index;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] i;
  } exp_t;

  logic [31:0] stim_q[$];
  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  compare_reduce_unit #(
    .FUNCTION_BITS(4),
    .BIT_WIDTH(32),
    .INDEX_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fn(fn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case a scenario stalls outside its own bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: strict compare, so the first occurrence of a tie wins.
  function automatic void model_push(input logic [3:0] f);
    logic [31:0] b;
    logic [15:0] bi;
    b  = stim_q[0];
    bi = 16'd0;
    for (int k = 1; k < stim_q.size(); k++) begin
      case (f)
        4'b0000, 4'b0010: if (stim_q[k] > b) begin b = stim_q[k]; bi = 16'(k); end
        4'b0001, 4'b0011: if (stim_q[k] < b) begin b = stim_q[k]; bi = 16'(k); end
        default: ;
      endcase
    end
    if (f > 4'b0011) begin
      b  = 32'd0;
      bi = 16'd0;
    end
    exp_q.push_back('{d: b, i: bi});
  endfunction

  function automatic exp_t pop_expected();
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Drives stim_q as one vector starting at a negedge; each beat is held until
  // accepted. Returns at the negedge after the last beat was accepted.
  task automatic send_vector(input logic [3:0] fn_first, input logic [3:0] fn_later,
                             input bit gaps);
    bit accepted;
    int waited;
    for (int k = 0; k < stim_q.size(); k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = stim_q[k];
      in_last  = (k == stim_q.size() - 1);
      fn       = (k == 0) ? fn_first : fn_later;
      waited   = 0;
      do begin
        accepted = in_ready;
        @(negedge clk);
        waited++;
      end while (!accepted && waited < 20);
      if (!accepted) begin
        checks++;
        failures++;
        $display("[TB] FAIL beat_accept: got in_ready=0 for %0d cycles expected acceptance", waited);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fn = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_out_valid_held: got %b expected 0", out_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_out_data: got %0h expected 0", out_data);
    end
    checks++;
    if (out_index !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_out_index: got %0d expected 0", out_index);
    end
  endtask

  task automatic test_argmax();
    exp_t e;
    stim_q = '{32'd5, 32'd9, 32'd3, 32'd9};
    model_push(4'b0010);
    send_vector(4'b0010, 4'b0010, 1'b0);
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL argmax_latency: got out_valid=%b expected 1", out_valid);
    end
    checks++;
    if (out_data !== e.d) begin
      failures++; $display("[TB] FAIL argmax_data: got %0d expected %0d", out_data, e.d);
    end
    checks++;
    if (out_index !== e.i) begin
      failures++; $display("[TB] FAIL argmax_index: got %0d expected %0d", out_index, e.i);
    end
  endtask

  task automatic test_min_bubbles();
    exp_t e;
    int   pulses;
    stim_q = '{32'd7, 32'd2, 32'd8};
    model_push(4'b0001);
    send_vector(4'b0001, 4'b0001, 1'b1);
    e = pop_expected();
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin
        checks++;
        if (out_data !== e.d) begin
          failures++; $display("[TB] FAIL min_data: got %0d expected %0d", out_data, e.d);
        end
        checks++;
        if (out_index !== e.i) begin
          failures++; $display("[TB] FAIL min_index: got %0d expected %0d", out_index, e.i);
        end
      end
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++; $display("[TB] FAIL min_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    stim_q = '{32'hFFFF_FFFF};
    model_push(4'b0000);
    send_vector(4'b0000, 4'b0000, 1'b0);
    e = pop_expected();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("[TB] FAIL bp_valid_cycle%0d: got %b expected 1", k, out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        failures++; $display("[TB] FAIL bp_in_ready_cycle%0d: got %b expected 0", k, in_ready);
      end
      checks++;
      if (out_data !== e.d || out_index !== e.i) begin
        failures++;
        $display("[TB] FAIL bp_hold_cycle%0d: got %0h/%0d expected %0h/%0d", k, out_data, out_index, e.d, e.i);
      end
    end
    out_ready = 1'b1;
    stim_q = '{32'h0000_1234};
    model_push(4'b0011);
    in_valid = 1'b1; in_data = 32'h0000_1234; in_last = 1'b1; fn = 4'b0011;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_next_accept: got out_valid=%b expected 1", out_valid);
    end
    checks++;
    if (out_data !== e.d || out_index !== e.i) begin
      failures++;
      $display("[TB] FAIL bp_next_result: got %0h/%0d expected %0h/%0d", out_data, out_index, e.d, e.i);
    end
  endtask

  task automatic test_fn_latched();
    exp_t e;
    stim_q = '{32'd4, 32'd1, 32'd6};
    model_push(4'b0011);
    send_vector(4'b0011, 4'b0000, 1'b0);
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL latched_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (out_data !== e.d) begin
      failures++; $display("[TB] FAIL latched_data: got %0d expected %0d", out_data, e.d);
    end
    checks++;
    if (out_index !== e.i) begin
      failures++; $display("[TB] FAIL latched_index: got %0d expected %0d", out_index, e.i);
    end
  endtask

  task automatic test_unsupported();
    exp_t e;
    stim_q = '{32'd3, 32'd4};
    model_push(4'b0110);
    send_vector(4'b0110, 4'b0110, 1'b0);
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL unsup_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (out_data !== e.d) begin
      failures++; $display("[TB] FAIL unsup_data: got %0d expected %0d", out_data, e.d);
    end
    checks++;
    if (out_index !== e.i) begin
      failures++; $display("[TB] FAIL unsup_index: got %0d expected %0d", out_index, e.i);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    stim_q = '{32'd1, 32'd7, 32'd7};
    model_push(4'b0000);
    send_vector(4'b0000, 4'b0000, 1'b0);
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i) begin
      failures++;
      $display("[TB] FAIL b2b_first: got v=%b %0d/%0d expected v=1 %0d/%0d", out_valid, out_data, out_index, e.d, e.i);
    end
    stim_q = '{32'd5, 32'd5};
    model_push(4'b0011);
    send_vector(4'b0011, 4'b0011, 1'b0);
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e.d || out_index !== e.i) begin
      failures++;
      $display("[TB] FAIL b2b_second: got v=%b %0d/%0d expected v=1 %0d/%0d", out_valid, out_data, out_index, e.d, e.i);
    end
  endtask

  task automatic test_reset_mid_vector();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd50; in_last = 1'b0; fn = 4'b0000;
    @(negedge clk);
    in_data = 32'd60;
    #2 reset = 1'b1;
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'd0) begin
      failures++; $display("[TB] FAIL rst_mid_data: got %0h expected 0", out_data);
    end
    checks++;
    if (out_index !== 16'd0) begin
      failures++; $display("[TB] FAIL rst_mid_index: got %0d expected 0", out_index);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    stim_q = '{32'd10, 32'd20};
    model_push(4'b0000);
    send_vector(4'b0000, 4'b0000, 1'b0);
    e = pop_expected();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_fresh_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (out_data !== e.d || out_index !== e.i) begin
      failures++;
      $display("[TB] FAIL rst_fresh_result: got %0d/%0d expected %0d/%0d", out_data, out_index, e.d, e.i);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_argmax();
    test_min_bubbles();
    test_backpressure();
    test_fn_latched();
    test_unsupported();
    test_back_to_back();
    test_reset_mid_vector();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
